// File: rtl/corr_peak_detect.sv
// Windowed peak search over a correlation sample stream.
// Reports max value, its position and a threshold hit through a one-entry valid/ready buffer.
module corr_peak_detect #(
   parameter int DATA_W  = 16,
   parameter int WIN_LEN = 16,
   parameter int IDX_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              continuous,
   input  logic [DATA_W-1:0] thresh,
   input  logic [DATA_W-1:0] y,
   input  logic              y_valid,
   output logic              peak_valid,
   input  logic              peak_ready,
   output logic [DATA_W-1:0] peak_value,
   output logic [IDX_W-1:0]  peak_index,
   output logic              peak_found,
   output logic              busy,
   output logic              overflow
);

   typedef enum logic {IDLE, SEARCH} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

   state_t            state_reg;
   logic [DATA_W-1:0] thresh_reg;
   logic [DATA_W-1:0] max_reg;
   logic [IDX_W-1:0]  idx_reg;
   logic [IDX_W-1:0]  count_reg;

   logic              accept;
   logic              win_end;
   logic              take;
   logic [DATA_W-1:0] max_next;
   logic [IDX_W-1:0]  idx_next;
   logic              found_next;

   // The closing sample joins the comparison combinationally so the result is ready one edge later.
   assign accept     = (state_reg == SEARCH) && y_valid;
   assign win_end    = accept && (count_reg == LAST_IDX);
   assign take       = (count_reg == '0) || (y > max_reg);
   assign max_next   = take ? y : max_reg;
   assign idx_next   = take ? count_reg : idx_reg;
   assign found_next = (max_next >= thresh_reg);

   assign busy = (state_reg == SEARCH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         thresh_reg <= '0;
         max_reg    <= '0;
         idx_reg    <= '0;
         count_reg  <= '0;
         peak_valid <= 1'b0;
         peak_value <= '0;
         peak_index <= '0;
         peak_found <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg  <= SEARCH;
                  thresh_reg <= thresh;
                  count_reg  <= '0;
                  max_reg    <= '0;
                  idx_reg    <= '0;
                  overflow   <= 1'b0;
               end
            end
            SEARCH: begin
               if (accept) begin
                  max_reg <= max_next;
                  idx_reg <= idx_next;
                  if (win_end) begin
                     count_reg <= '0;
                     if (continuous) begin
                        thresh_reg <= thresh;
                     end else begin
                        state_reg <= IDLE;
                     end
                  end else begin
                     count_reg <= count_reg + 1'b1;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase

         // A consumer draining the buffer on the same edge frees room for the new result.
         if (win_end) begin
            if (!peak_valid || peak_ready) begin
               peak_valid <= 1'b1;
               peak_value <= max_next;
               peak_index <= idx_next;
               peak_found <= found_next;
            end else begin
               overflow <= 1'b1;
            end
         end else if (peak_valid && peak_ready) begin
            peak_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_corr_peak_detect.sv
// Directed and randomized checks of corr_peak_detect against a window-queue reference model.
module tb_corr_peak_detect;
   localparam int DATA_W  = 16;
   localparam int WIN_LEN = 16;
   localparam int IDX_W   = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              continuous = 1'b0;
   logic [DATA_W-1:0] thresh = '0;
   logic [DATA_W-1:0] y = '0;
   logic              y_valid = 1'b0;
   logic              peak_ready = 1'b0;
   logic              peak_valid;
   logic [DATA_W-1:0] peak_value;
   logic [IDX_W-1:0]  peak_index;
   logic              peak_found;
   logic              busy;
   logic              overflow;

   int total = 0;
   int bad = 0;

   // Reference model state
   bit                m_busy, m_pv, m_found, m_ovf;
   int unsigned       m_val, m_idx;
   logic [DATA_W-1:0] m_thr;
   int unsigned       win[$];

   corr_peak_detect #(.DATA_W(DATA_W), .WIN_LEN(WIN_LEN), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
      .thresh(thresh), .y(y), .y_valid(y_valid), .peak_valid(peak_valid),
      .peak_ready(peak_ready), .peak_value(peak_value), .peak_index(peak_index),
      .peak_found(peak_found), .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_busy = 0; m_pv = 0; m_found = 0; m_ovf = 0;
      m_val = 0; m_idx = 0; m_thr = '0;
      win.delete();
   endtask

   // Advance model with the inputs now applied, then clock the DUT and settle past the edge.
   task automatic tick();
      bit ended = 0;
      bit fnd = 0;
      int unsigned mx = 0;
      int unsigned mi = 0;
      if (!m_busy) begin
         if (start) begin
            m_busy = 1; m_thr = thresh; m_ovf = 0; win.delete();
         end
      end else if (y_valid) begin
         win.push_back(int'(y));
         if (win.size() == WIN_LEN) begin
            mx = win[0]; mi = 0;
            foreach (win[k]) if (win[k] > mx) begin mx = win[k]; mi = k; end
            fnd = (mx >= m_thr);
            ended = 1;
            win.delete();
            if (continuous) m_thr = thresh;
            else m_busy = 0;
         end
      end
      if (m_pv && peak_ready)
         $display("xfer value=%0d index=%0d found=%0d", m_val, m_idx, m_found);
      if (ended) begin
         if (!m_pv || peak_ready) begin
            m_pv = 1; m_val = mx; m_idx = mi; m_found = fnd;
         end else begin
            m_ovf = 1;
         end
      end else if (m_pv && peak_ready) begin
         m_pv = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int unsigned v);
      y = DATA_W'(v); y_valid = 1'b1;
      tick();
      y_valid = 1'b0;
   endtask

   task automatic start_search(input int unsigned thr, input bit cont);
      thresh = DATA_W'(thr); continuous = cont; start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%0b want=1", busy); end
   endtask

   task automatic drain();
      peak_ready = 1'b1;
      tick();
      peak_ready = 1'b0;
      total++;
      if (peak_valid !== 1'b0) begin bad++; $display("FAIL drain_pv got=%0b want=0", peak_valid); end
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      total++;
      if ({peak_valid, peak_value, peak_index, peak_found, busy, overflow} !== 24'h0) begin
         bad++;
         $display("FAIL reset got=%h want=000000",
                  {peak_valid, peak_value, peak_index, peak_found, busy, overflow});
      end
   endtask

   task automatic test_basic();
      start_search(10, 0);
      for (int i = 1; i <= 15; i++) send(i);
      total++;
      if (peak_valid !== 1'b0) begin bad++; $display("FAIL basic_early got=%0b want=0", peak_valid); end
      send(16);
      total++;
      if ({peak_valid, peak_value, peak_index, peak_found, busy, overflow} !== {1'b1, 16'd16, 4'd15, 1'b1, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL basic got v=%0b val=%0d idx=%0d f=%0b busy=%0b ovf=%0b want 1/16/15/1/0/0",
                  peak_valid, peak_value, peak_index, peak_found, busy, overflow);
      end
      drain();
   endtask

   task automatic test_ties();
      int unsigned s[4] = '{5, 9, 9, 3};
      start_search(20, 0);
      for (int i = 0; i < 4; i++) send(s[i]);
      for (int i = 0; i < 12; i++) send(2);
      total++;
      if ({peak_valid, peak_value, peak_index, peak_found, busy} !== {1'b1, 16'd9, 4'd1, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL ties got v=%0b val=%0d idx=%0d f=%0b busy=%0b want 1/9/1/0/0",
                  peak_valid, peak_value, peak_index, peak_found, busy);
      end
      drain();
   endtask

   task automatic test_gapped();
      start_search(10, 0);
      for (int i = 1; i <= 16; i++) begin
         y = DATA_W'($urandom); y_valid = 1'b0;
         tick();
         send(i);
      end
      total++;
      if ({peak_valid, peak_value, peak_index, peak_found, busy} !== {1'b1, 16'd16, 4'd15, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL gapped got v=%0b val=%0d idx=%0d f=%0b busy=%0b want 1/16/15/1/0",
                  peak_valid, peak_value, peak_index, peak_found, busy);
      end
      drain();
   endtask

   task automatic test_overflow();
      start_search(30, 1);
      peak_ready = 1'b0;
      for (int k = 0; k < WIN_LEN; k++) send(k == 3 ? 40 : $urandom_range(0, 39));
      total++;
      if ({peak_valid, peak_value, peak_index, peak_found, overflow} !== {1'b1, 16'd40, 4'd3, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL ovf_a got v=%0b val=%0d idx=%0d f=%0b ovf=%0b want 1/40/3/1/0",
                  peak_valid, peak_value, peak_index, peak_found, overflow);
      end
      for (int k = 0; k < WIN_LEN; k++) send(k == 9 ? 50 : $urandom_range(0, 49));
      total++;
      if ({peak_valid, peak_value, peak_index, overflow, busy} !== {1'b1, 16'd40, 4'd3, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL ovf_b got v=%0b val=%0d idx=%0d ovf=%0b busy=%0b want 1/40/3/1/1",
                  peak_valid, peak_value, peak_index, overflow, busy);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 7; k++) send($urandom_range(0, 1000));
      rst_n = 1'b0;
      model_reset();
      #2;
      total++;
      if ({peak_valid, peak_value, peak_index, peak_found, busy, overflow} !== 24'h0) begin
         bad++;
         $display("FAIL rstmid got=%h want=000000",
                  {peak_valid, peak_value, peak_index, peak_found, busy, overflow});
      end
      rst_n = 1'b1;
      continuous = 1'b0;
      start_search(10, 0);
      for (int i = 1; i <= 16; i++) send(i);
      total++;
      if ({peak_valid, peak_value, peak_index, peak_found, busy, overflow} !== {1'b1, 16'd16, 4'd15, 1'b1, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL rstmid_res got v=%0b val=%0d idx=%0d f=%0b busy=%0b ovf=%0b want 1/16/15/1/0/0",
                  peak_valid, peak_value, peak_index, peak_found, busy, overflow);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      start_search(10, 1);
      peak_ready = 1'b0;
      for (int k = 0; k < WIN_LEN; k++) send(k == 3 ? 40 : $urandom_range(0, 39));
      for (int k = 0; k < WIN_LEN - 1; k++) send($urandom_range(0, 69));
      peak_ready = 1'b1;
      send(70);
      peak_ready = 1'b0;
      total++;
      if ({peak_valid, peak_value, peak_index, peak_found, overflow} !== {1'b1, 16'd70, 4'd15, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL b2b got v=%0b val=%0d idx=%0d f=%0b ovf=%0b want 1/70/15/1/0",
                  peak_valid, peak_value, peak_index, peak_found, overflow);
      end
      continuous = 1'b0;
      peak_ready = 1'b1;
      for (int k = 0; k < WIN_LEN; k++) send($urandom_range(0, 100));
      peak_ready = 1'b0;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle busy got=%0b want=0", busy); end
      drain();
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         start = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 49) == 0) continuous = ~continuous;
         thresh = DATA_W'($urandom);
         y = $urandom_range(0, 1) ? DATA_W'($urandom_range(0, 7)) : DATA_W'($urandom);
         y_valid = ($urandom_range(0, 3) != 0);
         peak_ready = ($urandom_range(0, 2) == 0);
         tick();
         total++;
         if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy c=%0d got=%0b want=%0b", c, busy, m_busy); end
         total++;
         if (peak_valid !== m_pv) begin bad++; $display("FAIL rnd_pv c=%0d got=%0b want=%0b", c, peak_valid, m_pv); end
         total++;
         if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf c=%0d got=%0b want=%0b", c, overflow, m_ovf); end
         if (m_pv) begin
            total++;
            if ({peak_value, peak_index, peak_found} !== {DATA_W'(m_val), IDX_W'(m_idx), m_found}) begin
               bad++;
               $display("FAIL rnd_res c=%0d got val=%0d idx=%0d f=%0b want val=%0d idx=%0d f=%0b",
                        c, peak_value, peak_index, peak_found, m_val, m_idx, m_found);
            end
         end
      end
      start = 1'b0; y_valid = 1'b0; peak_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ties();
      test_gapped();
      test_overflow();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
